// File: rtl/cpu_pkg.sv
// Shared data-path constants and types for the CPU register file slice.
package cpu_pkg;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_NREGS      = 32;
    localparam int unsigned DEF_CNT_WIDTH  = 16;
    localparam int unsigned DEF_ADDR_WIDTH = $clog2(DEF_NREGS);

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_WIDTH-1:0]      word_t;

    localparam reg_addr_t ZERO_ADDR = '0;

    // True when the address names the hard-wired zero register.
    function automatic logic addr_is_zero(input int unsigned addr);
        return addr == 32'(ZERO_ADDR);
    endfunction

endpackage

// File: rtl/scoreboard_busy.sv
// Per-register busy scoreboard: reserve on issue, release on writeback,
// flush-clear, and the RAW/WAW hazard check that produces issue_ready.
module scoreboard_busy
    import cpu_pkg::*;
#(
    parameter int unsigned NREGS      = DEF_NREGS,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    input  logic                  i_fwd1,
    input  logic                  i_fwd2,
    input  logic                  i_issue_valid,
    input  logic                  i_issue_use1,
    input  logic                  i_issue_use2,
    input  logic [ADDR_WIDTH-1:0] i_issue_rd,
    input  logic                  i_wb_alu_en,
    input  logic [ADDR_WIDTH-1:0] i_wb_alu_addr,
    input  logic                  i_wb_mem_en,
    input  logic [ADDR_WIDTH-1:0] i_wb_mem_addr,
    input  logic                  i_flush,
    output logic                  o_full1_c,
    output logic                  o_full2_c,
    output logic                  o_stall_c,
    output logic                  o_issue_ready_c
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_full1;
    logic             w_full2;
    logic             w_stall;
    logic             w_fire;

    // Operand validity; forwarding (when present) masks a pending register.
    always_comb begin
        w_full1 = !r_busy[i_raddr1] || i_fwd1;
        w_full2 = !r_busy[i_raddr2] || i_fwd2;
    end

    // WAW term deliberately ignores forwarding: the old reservation must retire.
    always_comb begin
        w_stall = i_issue_valid &&
                  ((i_issue_use1 && !w_full1) ||
                   (i_issue_use2 && !w_full2) ||
                   r_busy[i_issue_rd]);
        w_fire  = i_issue_valid && !w_stall && !i_flush;
    end

    // Clears first, then the reservation, so reserve wins on a same-address collision.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (i_wb_alu_en && (i_wb_alu_addr == ADDR_WIDTH'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (i_wb_mem_en && (i_wb_mem_addr == ADDR_WIDTH'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (w_fire && (i_issue_rd == ADDR_WIDTH'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
        if (i_flush) begin
            w_busy_nxt = '0;
        end
        if (ZR) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_full1_c       = w_full1;
    assign o_full2_c       = w_full2;
    assign o_stall_c       = w_stall;
    assign o_issue_ready_c = !w_stall;

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with busy scoreboard, two writeback ports and a saturating
// stall counter. Define SCOREBOARD_BYPASS_EN to forward writebacks to reads.
module scoreboard_regfile
    import cpu_pkg::*;
#(
    parameter  int unsigned WIDTH      = DEF_WIDTH,
    parameter  int unsigned NREGS      = DEF_NREGS,
    parameter  int unsigned ZERO_REG   = 1,
    parameter  int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int unsigned ADDR_WIDTH = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [WIDTH-1:0]      rdata1,
    output logic [WIDTH-1:0]      rdata2,
    output logic                  is_full_rnum1,
    output logic                  is_full_rnum2,
    input  logic                  issue_valid,
    input  logic                  issue_use1,
    input  logic                  issue_use2,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  wb_alu_en,
    input  logic [ADDR_WIDTH-1:0] wb_alu_addr,
    input  logic [WIDTH-1:0]      wb_alu_data,
    input  logic                  wb_mem_en,
    input  logic [ADDR_WIDTH-1:0] wb_mem_addr,
    input  logic [WIDTH-1:0]      wb_mem_data,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    localparam bit                   ZR      = (ZERO_REG != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]     r_regs [NREGS];
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic             w_alu_we;
    logic             w_mem_we;
    logic [WIDTH-1:0] w_rdata1;
    logic [WIDTH-1:0] w_rdata2;
    logic             w_fwd1;
    logic             w_fwd2;
    logic             w_full1;
    logic             w_full2;
    logic             w_stall;
    logic             w_issue_ready;

    // Writes to the zero register are dropped at the port.
    always_comb begin
        w_alu_we = wb_alu_en && !(ZR && addr_is_zero(32'(wb_alu_addr)));
        w_mem_we = wb_mem_en && !(ZR && addr_is_zero(32'(wb_mem_addr)));
    end

    // Read muxes; forwarded data (mem before alu) overrides the array.
    always_comb begin
        w_rdata1 = r_regs[raddr1];
        w_rdata2 = r_regs[raddr2];
        w_fwd1   = 1'b0;
        w_fwd2   = 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
        if (w_mem_we && (wb_mem_addr == raddr1)) begin
            w_rdata1 = wb_mem_data;
            w_fwd1   = 1'b1;
        end else if (w_alu_we && (wb_alu_addr == raddr1)) begin
            w_rdata1 = wb_alu_data;
            w_fwd1   = 1'b1;
        end
        if (w_mem_we && (wb_mem_addr == raddr2)) begin
            w_rdata2 = wb_mem_data;
            w_fwd2   = 1'b1;
        end else if (w_alu_we && (wb_alu_addr == raddr2)) begin
            w_rdata2 = wb_alu_data;
            w_fwd2   = 1'b1;
        end
`endif
    end

    scoreboard_busy #(
        .NREGS      (NREGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_busy (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_raddr1        (raddr1),
        .i_raddr2        (raddr2),
        .i_fwd1          (w_fwd1),
        .i_fwd2          (w_fwd2),
        .i_issue_valid   (issue_valid),
        .i_issue_use1    (issue_use1),
        .i_issue_use2    (issue_use2),
        .i_issue_rd      (issue_rd),
        .i_wb_alu_en     (wb_alu_en),
        .i_wb_alu_addr   (wb_alu_addr),
        .i_wb_mem_en     (wb_mem_en),
        .i_wb_mem_addr   (wb_mem_addr),
        .i_flush         (flush),
        .o_full1_c       (w_full1),
        .o_full2_c       (w_full2),
        .o_stall_c       (w_stall),
        .o_issue_ready_c (w_issue_ready)
    );

    // Data array; the later mem assignment wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_alu_we) begin
                r_regs[wb_alu_addr] <= wb_alu_data;
            end
            if (w_mem_we) begin
                r_regs[wb_mem_addr] <= wb_mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign rdata1        = w_rdata1;
    assign rdata2        = w_rdata2;
    assign is_full_rnum1 = w_full1;
    assign is_full_rnum2 = w_full2;
    assign issue_ready   = w_issue_ready;
    assign stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Bench for scoreboard_regfile: directed vector table, counter saturation,
// mid-operation reset, then random traffic against a register/busy model.
module tb_scoreboard_regfile;

`ifdef SCOREBOARD_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        is_full_rnum1, is_full_rnum2;
    logic        issue_valid, issue_use1, issue_use2;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        wb_alu_en;
    logic [4:0]  wb_alu_addr;
    logic [31:0] wb_alu_data;
    logic        wb_mem_en;
    logic [4:0]  wb_mem_addr;
    logic [31:0] wb_mem_data;
    logic        flush;
    logic [15:0] stall_count;

    int n_chk  = 0;
    int n_fail = 0;

    scoreboard_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .raddr1        (raddr1),
        .raddr2        (raddr2),
        .rdata1        (rdata1),
        .rdata2        (rdata2),
        .is_full_rnum1 (is_full_rnum1),
        .is_full_rnum2 (is_full_rnum2),
        .issue_valid   (issue_valid),
        .issue_use1    (issue_use1),
        .issue_use2    (issue_use2),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .wb_alu_en     (wb_alu_en),
        .wb_alu_addr   (wb_alu_addr),
        .wb_alu_data   (wb_alu_data),
        .wb_mem_en     (wb_mem_en),
        .wb_mem_addr   (wb_mem_addr),
        .wb_mem_data   (wb_mem_data),
        .flush         (flush),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: plain arrays updated from the behavioural rules.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    int unsigned m_cnt;

    function automatic bit m_fwd_alu(input logic [4:0] a);
        return (BYP != 0) && wb_alu_en && (wb_alu_addr == a) && (a != '0);
    endfunction

    function automatic bit m_fwd_mem(input logic [4:0] a);
        return (BYP != 0) && wb_mem_en && (wb_mem_addr == a) && (a != '0);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        if (a == '0) return 32'h0;
        if (m_fwd_mem(a)) return wb_mem_data;
        if (m_fwd_alu(a)) return wb_alu_data;
        return m_regs[a];
    endfunction

    function automatic bit m_full(input logic [4:0] a);
        if (a == '0) return 1'b1;
        if (m_fwd_mem(a) || m_fwd_alu(a)) return 1'b1;
        return !m_busy[a];
    endfunction

    function automatic bit m_stall();
        return issue_valid && ((issue_use1 && !m_full(raddr1)) ||
                               (issue_use2 && !m_full(raddr2)) ||
                               m_busy[issue_rd]);
    endfunction

    task automatic m_update();
        bit st;
        bit fire;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
            m_cnt = 0;
        end else begin
            st   = m_stall();
            fire = issue_valid && !st && !flush;
            if (st && m_cnt < 65535) m_cnt++;
            if (wb_alu_en && wb_alu_addr != '0) begin
                m_regs[wb_alu_addr] = wb_alu_data;
                m_busy[wb_alu_addr] = 1'b0;
            end
            if (wb_mem_en && wb_mem_addr != '0) begin
                m_regs[wb_mem_addr] = wb_mem_data;
                m_busy[wb_mem_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (fire && issue_rd != '0) begin
                m_busy[issue_rd] = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("rand_rdata1", rdata1, m_rdata(raddr1));
        check("rand_rdata2", rdata2, m_rdata(raddr2));
        check("rand_full1", 32'(is_full_rnum1), 32'(m_full(raddr1)));
        check("rand_full2", 32'(is_full_rnum2), 32'(m_full(raddr2)));
        check("rand_ready", 32'(issue_ready), 32'(!m_stall()));
        check("rand_count", 32'(stall_count), m_cnt);
    endtask

    task automatic set_idle();
        rst = 1'b0; raddr1 = '0; raddr2 = '0;
        issue_valid = 1'b0; issue_use1 = 1'b0; issue_use2 = 1'b0; issue_rd = '0;
        wb_alu_en = 1'b0; wb_alu_addr = '0; wb_alu_data = '0;
        wb_mem_en = 1'b0; wb_mem_addr = '0; wb_mem_data = '0;
        flush = 1'b0;
    endtask

    // Inputs change on the falling edge; the model follows the rising edge.
    task automatic tick();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic [4:0]  ra1;
        logic        iv;
        logic        u1;
        logic [4:0]  rd;
        logic        ae;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        me;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        fl;
        logic        chk;
        logic [31:0] e_rd1;
        logic        e_f1;
        logic        e_rdy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [$];

    task automatic addv(input int r, input int ra1, input int iv, input int u1, input int rd,
                        input int ae, input int aa, input logic [31:0] ad,
                        input int me, input int ma, input logic [31:0] md,
                        input int fl, input int chk,
                        input logic [31:0] e_rd1, input int e_f1, input int e_rdy, input int e_cnt);
        vec_t v;
        v.rst = 1'(r);   v.ra1 = 5'(ra1); v.iv = 1'(iv); v.u1 = 1'(u1); v.rd = 5'(rd);
        v.ae  = 1'(ae);  v.aa = 5'(aa);   v.ad = ad;
        v.me  = 1'(me);  v.ma = 5'(ma);   v.md = md;
        v.fl  = 1'(fl);  v.chk = 1'(chk);
        v.e_rd1 = e_rd1; v.e_f1 = 1'(e_f1); v.e_rdy = 1'(e_rdy); v.e_cnt = 16'(e_cnt);
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] bv_dead;
        logic [31:0] bv_12;
        logic [31:0] bv_2;
        logic [31:0] bv_a5;
        logic [31:0] bv_5a;
        bv_dead = (BYP != 0) ? 32'hDEADBEEF : 32'h0;
        bv_12   = (BYP != 0) ? 32'h12 : 32'h0;
        bv_2    = (BYP != 0) ? 32'h2 : 32'h0;
        bv_a5   = (BYP != 0) ? 32'hA5 : 32'h0;
        bv_5a   = (BYP != 0) ? 32'h5A : 32'hA5;

        //   rst ra1 iv u1 rd  ae aa ad            me ma md     fl chk  e_rd1        f1   rdy  cnt
        addv(1, 0,  0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0, 0, 0,   32'h0,       1,   1,   0);
        addv(0, 5,  0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   0);
        addv(0, 0,  1, 0, 3,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   0);
        addv(0, 3,  1, 1, 10, 0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       0,   0,   0);
        addv(0, 3,  1, 1, 10, 1, 3, 32'hDEADBEEF, 0, 0, 32'h0, 0, 1,   bv_dead,     BYP, BYP, 1);
        addv(0, 3,  1, 1, 11, 0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'hDEADBEEF,1,   1,   2-BYP);
        addv(0, 11, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0, 1, 1,   32'h0,       0,   1,   2-BYP);
        addv(0, 7,  1, 0, 7,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   2-BYP);
        addv(0, 7,  1, 0, 7,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       0,   0,   2-BYP);
        addv(0, 7,  1, 0, 7,  0, 0, 32'h0,        1, 7, 32'h12,0, 1,   bv_12,       BYP, 0,   3-BYP);
        addv(0, 7,  1, 0, 7,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h12,      1,   1,   4-BYP);
        addv(0, 4,  0, 0, 0,  1, 4, 32'h1,        1, 4, 32'h2, 0, 1,   bv_2,        1,   1,   4-BYP);
        addv(0, 4,  0, 0, 0,  1, 7, 32'h55,       0, 0, 32'h0, 0, 1,   32'h2,       1,   1,   4-BYP);
        addv(0, 0,  1, 1, 0,  1, 0, 32'hFF,       0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   4-BYP);
        addv(0, 0,  1, 1, 0,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   4-BYP);
        addv(0, 0,  1, 0, 1,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   4-BYP);
        addv(0, 0,  1, 0, 2,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   4-BYP);
        addv(0, 1,  1, 0, 9,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       0,   1,   4-BYP);
        addv(0, 9,  1, 0, 12, 0, 0, 32'h0,        0, 0, 32'h0, 1, 1,   32'h0,       0,   1,   4-BYP);
        addv(0, 12, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   4-BYP);
        addv(0, 9,  0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   4-BYP);
        addv(0, 1,  0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h0,       1,   1,   4-BYP);
        addv(0, 5,  1, 0, 5,  1, 5, 32'hA5,       0, 0, 32'h0, 0, 1,   bv_a5,       1,   1,   4-BYP);
        addv(0, 5,  0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'hA5,      0,   1,   4-BYP);
        addv(0, 5,  0, 0, 0,  0, 0, 32'h0,        1, 5, 32'h5A,0, 1,   bv_5a,       BYP, 1,   4-BYP);
        addv(0, 5,  0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0, 0, 1,   32'h5A,      1,   1,   4-BYP);

        set_idle();
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            set_idle();
            rst = vecs[k].rst; raddr1 = vecs[k].ra1;
            issue_valid = vecs[k].iv; issue_use1 = vecs[k].u1; issue_rd = vecs[k].rd;
            wb_alu_en = vecs[k].ae; wb_alu_addr = vecs[k].aa; wb_alu_data = vecs[k].ad;
            wb_mem_en = vecs[k].me; wb_mem_addr = vecs[k].ma; wb_mem_data = vecs[k].md;
            flush = vecs[k].fl;
            #1;
            if (vecs[k].chk) begin
                check($sformatf("vec%0d_rdata1", k), rdata1, vecs[k].e_rd1);
                check($sformatf("vec%0d_full1", k), 32'(is_full_rnum1), 32'(vecs[k].e_f1));
                check($sformatf("vec%0d_ready", k), 32'(issue_ready), 32'(vecs[k].e_rdy));
                check($sformatf("vec%0d_count", k), 32'(stall_count), 32'(vecs[k].e_cnt));
            end
            tick();
        end

        // Reserve r3, then hold a WAW stall long enough to saturate the counter.
        set_idle();
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1 check("sat_first_issue", 32'(issue_ready), 32'h1);
        tick();
        for (int c = 0; c < 65536 + 5; c++) tick();
        #1;
        check("sat_count", 32'(stall_count), 32'hFFFF);
        check("sat_ready", 32'(issue_ready), 32'h0);

        // Reset overrides a concurrent issue, flush and writeback.
        rst = 1'b1; flush = 1'b1; issue_rd = 5'd6;
        wb_alu_en = 1'b1; wb_alu_addr = 5'd6; wb_alu_data = 32'h77;
        tick();
        set_idle();
        raddr1 = 5'd6; raddr2 = 5'd3;
        issue_valid = 1'b1; issue_use2 = 1'b1; issue_rd = 5'd3;
        #1;
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_full1", 32'(is_full_rnum1), 32'h1);
        check("rst_full2", 32'(is_full_rnum2), 32'h1);
        check("rst_count", 32'(stall_count), 32'h0);
        check("rst_ready", 32'(issue_ready), 32'h1);
        tick();

        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 149) == 0);
            raddr1      = 5'($urandom_range(0, 7));
            raddr2      = 5'($urandom_range(0, 7));
            issue_valid = 1'($urandom_range(0, 1));
            issue_use1  = 1'($urandom_range(0, 1));
            issue_use2  = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            wb_alu_en   = ($urandom_range(0, 2) == 0);
            wb_alu_addr = 5'($urandom_range(0, 7));
            wb_alu_data = $urandom;
            wb_mem_en   = ($urandom_range(0, 2) == 0);
            wb_mem_addr = 5'($urandom_range(0, 7));
            wb_mem_data = $urandom;
            flush       = ($urandom_range(0, 19) == 0);
            #1 check_model();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
Name: scoreboard_regfile

Overview:
- Parametrised register file with a per-register busy scoreboard, for the next-generation CPU data path where the ALU and the load unit write back independently.
- Provides two combinational read ports with per-operand valid flags (is_full_rnum1/2), an issue handshake that reserves the destination register, and two writeback ports.
- Also provides a flush input and a saturating stall counter.
- Replaces the plain register file; control_path_cpu consumes issue_ready to stall.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(NREGS), localparam, register address width.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- raddr1  in  ADDR_WIDTH  source 1 address.
- raddr2  in  ADDR_WIDTH  source 2 address.
- rdata1  out  WIDTH  source 1 data.
- rdata2  out  WIDTH  source 2 data.
- is_full_rnum1  out  1  source 1 value is valid (not pending).
- is_full_rnum2  out  1  source 2 value is valid (not pending).
- issue_valid  in  1  control path requests issue of an instruction that writes a register.
- issue_use1  in  1  the instruction reads source 1.
- issue_use2  in  1  the instruction reads source 2.
- issue_rd  in  ADDR_WIDTH  destination register to reserve.
- issue_ready  out  1  issue may proceed this cycle.
- wb_alu_en  in  1  ALU writeback strobe.
- wb_alu_addr  in  ADDR_WIDTH  ALU writeback address.
- wb_alu_data  in  WIDTH  ALU writeback data.
- wb_mem_en  in  1  load writeback strobe.
- wb_mem_addr  in  ADDR_WIDTH  load writeback address.
- wb_mem_data  in  WIDTH  load writeback data.
- flush  in  1  clear all reservations (squash).
- stall_count  out  CNT_WIDTH  saturating count of stalled issue cycles.

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset: all registers 0, all busy bits 0, stall_count 0. After reset rdata1/2 = 0, is_full_rnum1/2 = 1 and issue_ready = 1.
- Reads are combinational:
  - rdata = regs[raddr].
  - is_full_rnumN = !busy[raddrN].
  - With ZERO_REG=1, raddr 0 gives data 0 and full 1.
- Stall, all evaluated on registered busy state:
  - stall = issue_valid && ((issue_use1 && !full1) || (issue_use2 && !full2) || busy[issue_rd]). The last term is the WAW hazard.
  - issue_ready = !stall. issue_ready is also 1 when issue_valid = 0.
- Issue fires when issue_valid && issue_ready && !flush. It sets busy[issue_rd] on the next edge; with ZERO_REG=1 and issue_rd = 0 nothing is set.
- Writeback: each enabled port writes regs[addr] <= data and clears busy[addr] on the next edge.
  - Both ports to the same address in the same cycle: the mem port data wins and busy is cleared.
  - Writes to register 0 are dropped when ZERO_REG=1.
  - A writeback to a non-busy register is legal; data is written and busy stays 0.
- Issue and writeback to the same address in the same cycle (possible only for a non-busy rd): the data is written and busy is set, so reserve wins.
- flush clears every busy bit on the next edge and blocks the issue that cycle. Writebacks in the flush cycle still update data.
- stall_count increments on every cycle where issue_valid && stall. It saturates at all-ones and clears only on rst.
- Reset asserted mid-operation overrides flush, issue and writeback in that cycle.

Optional Feature:
- Macro: SCOREBOARD_BYPASS_EN.
- Defined: an enabled writeback whose address matches raddrN forwards its data to rdataN combinationally and forces is_full_rnumN = 1, with mem having priority over alu. The stall equation uses these bypassed flags, which removes one stall cycle per RAW dependency. The WAW term always uses registered busy.
- Undefined: no forwarding. The value is visible the cycle after writeback.

Decomposition:
- Package cpu_pkg holds:
  - default WIDTH and NREGS constants;
  - typedef reg_addr_t (logic [ADDR_WIDTH-1:0]);
  - typedef word_t (logic [WIDTH-1:0]);
  - constant ZERO_ADDR.
- One sub-module, scoreboard_busy: the NREGS busy-bit vector with set/clear/flush logic and the hazard check. It is instantiated once. The data array and read muxes stay in the top.

Test Plan:
- Reset then read r5 -> rdata1 = 0, is_full_rnum1 = 1, issue_ready = 1, stall_count = 0.
- Issue rd=3, then next cycle issue with use1 and raddr1=3 -> issue_ready = 0, stall_count = 1.
  - Then wb_alu 3 <= 0xDEADBEEF -> next cycle rdata1 = 0xDEADBEEF, full 1, issue proceeds.
  - With SCOREBOARD_BYPASS_EN, the issue proceeds in the writeback cycle itself and stall_count stays 1.
- Issue rd=7, then issue rd=7 again -> stalled (WAW) until wb_mem 7 <= 0x12.
- Same-cycle wb_alu 4 <= 0x1 and wb_mem 4 <= 0x2 -> r4 = 0x2, busy[4] = 0.
- Issue rd=0, wb 0 <= 0xFF -> r0 reads 0 and is never busy.
- Reserve r1, r2 and r9, then assert flush while issue_valid=1 -> that issue is not accepted; next cycle all full flags = 1.
- Hold a stall for 2^16+5 cycles -> stall_count = 0xFFFF.
